// File: rtl/spi_txn_arbiter_pkg.sv
// Shared definitions for the SPI transaction arbiter: frame geometry,
// FSM state encoding and an index-width helper.
package spi_txn_arbiter_pkg;

  localparam int SPI_WIDTH = 13;
  localparam int SPI_NREQ  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_e;

  // Width of a counter/index that must hold 0..n-1; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_txn_arbiter_rr.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
// Produces a one-hot grant, its binary index and a valid flag.
module rr_arbiter
  import spi_txn_arbiter_pkg::*;
#(
  parameter  int N  = SPI_NREQ,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  localparam logic [N-1:0] ONE_N = N'(1);

  logic [2*N-1:0] rot;
  int             pos;

  always_comb begin
    rot   = {req, req} >> ptr;
    valid = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      if (!valid && rot[k]) begin
        valid = 1'b1;
        pos   = int'(ptr) + k;
      end
    end
    if (pos >= N) pos = pos - N;
    idx = IW'(pos);
    gnt = valid ? (ONE_N << idx) : '0;
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI master frame engine among NREQ requesters: round-robin grant,
// frame launch, completion/watchdog handling and an enforced inter-frame gap.
//
//   state | meaning
//   IDLE  | arbitrate; on any request latch winner and frame, pulse m_start
//   START | m_start high for this single cycle; watchdog cleared
//   WAIT  | frame in flight; m_done or watchdog expiry ends it with ack
//   GAP   | enforced idle between frames; requests ignored
module spi_txn_arbiter
  import spi_txn_arbiter_pkg::*;
#(
  parameter int NREQ           = SPI_NREQ,
  parameter int WIDTH          = SPI_WIDTH,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_dat,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic                  err,
  output logic [WIDTH-1:0]      rsp_dat,
  output logic                  m_start,
  output logic [WIDTH-1:0]      m_tx_dat,
  input  logic                  m_done,
  input  logic [WIDTH-1:0]      m_rx_dat
);

  localparam int IW = idx_w(NREQ);
  localparam int GW = idx_w(GAP_CYCLES);
  localparam int TW = idx_w(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     ptr_q, win_q;
  logic [GW-1:0]     gap_q;
  logic [TW-1:0]     tmo_q;
  logic [NREQ-1:0]   arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic              arb_valid;
  logic [WIDTH-1:0]  sel_dat;
  logic              done_ok, done_tmo;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == IW'(i)) sel_dat = req_dat[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d  = state_q;
    done_ok  = 1'b0;
    done_tmo = 1'b0;
    case (state_q)
      ST_IDLE:  if (arb_valid) state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        // A completion landing on the watchdog's last cycle is still a good frame.
        if (m_done) done_ok = 1'b1;
        else if (TIMEOUT_CYCLES != 0 && tmo_q == TMO_LAST) done_tmo = 1'b1;
        if (done_ok || done_tmo) state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP:   if (gap_q == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= '0;
      ack      <= '0;
      err      <= 1'b0;
      m_start  <= 1'b0;
      rsp_dat  <= '0;
      m_tx_dat <= '0;
      ptr_q    <= '0;
      win_q    <= '0;
      gap_q    <= '0;
      tmo_q    <= '0;
    end else begin
      m_start <= 1'b0;
      ack     <= '0;
      err     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            gnt      <= arb_gnt;
            win_q    <= arb_idx;
            m_tx_dat <= sel_dat;
            m_start  <= 1'b1;
          end
        end
        ST_START: tmo_q <= '0;
        ST_WAIT: begin
          if (done_ok || done_tmo) begin
            ack   <= gnt;
            err   <= done_tmo;
            gnt   <= '0;
            ptr_q <= (win_q == IDX_LAST) ? '0 : win_q + 1'b1;
            gap_q <= GAP_LOAD;
            if (done_ok) rsp_dat <= m_rx_dat;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_GAP: if (gap_q != '0) gap_q <= gap_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench for spi_txn_arbiter: vector table plus corner-case sequences,
// with start/ack expectations queued at stimulus time and checked as the DUT responds.
module tb_spi_txn_arbiter;

  localparam int NREQ  = 3;
  localparam int WIDTH = 13;
  localparam int GAP   = 4;
  localparam int TMO   = 100;

  typedef struct {
    int               idx;
    logic [WIDTH-1:0] tx;
    int               lat;
  } start_exp_t;

  typedef struct {
    int               idx;
    logic             err;
    logic [WIDTH-1:0] rsp;
    int               lat;
  } ack_exp_t;

  typedef struct {
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] dat;
    logic [WIDTH-1:0]      rx;
    int                    delay;
    int                    exp_idx;
    logic [WIDTH-1:0]      exp_tx;
  } vec_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_dat;
  logic [NREQ-1:0]       gnt, ack;
  logic                  err;
  logic [WIDTH-1:0]      rsp_dat;
  logic                  m_start;
  logic [WIDTH-1:0]      m_tx_dat;
  logic                  m_done;
  logic [WIDTH-1:0]      m_rx_dat;

  spi_txn_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_dat  (req_dat),
    .gnt      (gnt),
    .ack      (ack),
    .err      (err),
    .rsp_dat  (rsp_dat),
    .m_start  (m_start),
    .m_tx_dat (m_tx_dat),
    .m_done   (m_done),
    .m_rx_dat (m_rx_dat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_start = 0, n_ack = 0, tgt_start = 0, tgt_ack = 0;
  int resp_delay = 1;
  int countdown = 0;
  int start_cyc = 0, last_ack_cyc = 0, req_cyc = 0;
  bit have_ack = 0;
  bit spur_go = 0;
  logic [WIDTH-1:0] resp_rx, spur_dat, exp_cur_tx, last_rsp;
  start_exp_t start_q[$];
  ack_exp_t   ack_q[$];
  vec_t       vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_txn(input int idx, input logic [WIDTH-1:0] tx, input logic e,
                          input logic [WIDTH-1:0] rsp, input int slat, input int alat);
    start_q.push_back('{idx: idx, tx: tx, lat: slat});
    ack_q.push_back('{idx: idx, err: e, rsp: rsp, lat: alat});
    tgt_start++;
    tgt_ack++;
    if (!e) last_rsp = rsp;
  endtask

  task automatic wait_start(input string name);
    int budget = 400;
    while (n_start < tgt_start && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (n_start < tgt_start) begin
      checks++;
      errors++;
      $display("FAIL %s: m_start count %0d, expected %0d before timeout", name, n_start, tgt_start);
    end
    #1;
  endtask

  task automatic wait_ack(input string name);
    int budget = 400;
    while (n_ack < tgt_ack && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (n_ack < tgt_ack) begin
      checks++;
      errors++;
      $display("FAIL %s: ack count %0d, expected %0d before timeout", name, n_ack, tgt_ack);
    end
    #1;
  endtask

  task automatic monitor_loop();
    start_exp_t se;
    ack_exp_t   ae;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (gnt != '0) chk("gnt_onehot", 64'($countones(gnt)), 64'(1));
        if (m_start) begin
          n_start++;
          if (start_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start: got m_start with gnt %b, expected none", gnt);
          end else begin
            se = start_q.pop_front();
            chk("start_gnt", 64'(gnt), 64'(1) << se.idx);
            chk("start_tx", 64'(m_tx_dat), 64'(se.tx));
            if (se.lat != 0) chk("req_to_start", 64'(cyc - req_cyc), 64'(se.lat));
            exp_cur_tx = se.tx;
          end
          if (have_ack) begin
            checks++;
            if (cyc - last_ack_cyc - 1 < GAP) begin
              errors++;
              $display("FAIL gap_len: got %0d idle cycles, required >= %0d", cyc - last_ack_cyc - 1, GAP);
            end
          end
          start_cyc = cyc;
          if (resp_delay >= 0) countdown = resp_delay;
        end else if (gnt != '0) begin
          chk("tx_stable", 64'(m_tx_dat), 64'(exp_cur_tx));
        end
        if (ack != '0 || err) begin
          n_ack++;
          if (ack_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got ack %b err %b, expected none", ack, err);
          end else begin
            ae = ack_q.pop_front();
            chk("ack_vec", 64'(ack), 64'(1) << ae.idx);
            chk("ack_err", 64'(err), 64'(ae.err));
            chk("ack_rsp", 64'(rsp_dat), 64'(ae.rsp));
            if (ae.lat != 0) chk("ack_latency", 64'(cyc - start_cyc), 64'(ae.lat));
          end
          last_ack_cyc = cyc;
          have_ack = 1;
        end
      end
    end
  endtask

  task automatic responder_loop();
    forever begin
      @(posedge clk);
      #1;
      m_done   = 1'b0;
      m_rx_dat = WIDTH'($urandom);
      if (countdown == 1) begin
        m_done   = 1'b1;
        m_rx_dat = resp_rx;
      end
      if (countdown > 0) countdown--;
      if (spur_go) begin
        m_done   = 1'b1;
        m_rx_dat = spur_dat;
        spur_go  = 0;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, 64'(gnt), 64'(0));
    chk({tag, "_ack"}, 64'(ack), 64'(0));
    chk({tag, "_err"}, 64'(err), 64'(0));
    chk({tag, "_m_start"}, 64'(m_start), 64'(0));
    chk({tag, "_rsp_dat"}, 64'(rsp_dat), 64'(0));
    chk({tag, "_m_tx_dat"}, 64'(m_tx_dat), 64'(0));
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    req_dat  = '0;
    m_done   = 1'b0;
    m_rx_dat = '0;
    resp_rx  = '0;
    spur_dat = '0;
    last_rsp = '0;
    exp_cur_tx = '0;

    // Round-robin pointer evolves through the table: 0,1,0,1,2,1,2 -> ends at 0.
    vecs[0] = '{3'b001, {13'h111, 13'h222, 13'h2cc}, 13'h6d9, 1, 0, 13'h2cc};
    vecs[1] = '{3'b101, {13'h0f0, 13'h0a5, 13'h333}, 13'h1abc, 3, 2, 13'h0f0};
    vecs[2] = '{3'b011, {13'h1000, 13'h0777, 13'h0001}, 13'h0002, 2, 0, 13'h0001};
    vecs[3] = '{3'b011, {13'h1000, 13'h0777, 13'h0001}, 13'h1fff, 6, 1, 13'h0777};
    vecs[4] = '{3'b001, {13'h1555, 13'h0aaa, 13'h1234}, 13'h0000, 1, 0, 13'h1234};
    vecs[5] = '{3'b110, {13'h0123, 13'h1ffe, 13'h0456}, 13'h0abc, 4, 1, 13'h1ffe};
    vecs[6] = '{3'b100, {13'h1fff, 13'h0000, 13'h0000}, 13'h0e0e, 2, 2, 13'h1fff};

    fork
      monitor_loop();
      responder_loop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      req_dat    = vecs[i].dat;
      resp_rx    = vecs[i].rx;
      resp_delay = vecs[i].delay;
      // From idle, m_start is seen two negedges after the req drive (one clock of latency).
      push_txn(vecs[i].exp_idx, vecs[i].exp_tx, 1'b0, vecs[i].rx, (i == 0) ? 2 : 0, 0);
      req_cyc = cyc;
      req     = vecs[i].req;
      wait_start("vec_start");
      req = '0;
      wait_ack("vec_ack");
    end

    // All three held from ptr=0: order 0,1,2,0.
    req_dat    = {13'h0c2, 13'h0b1, 13'h0a0};
    resp_rx    = 13'h05a5;
    resp_delay = 2;
    push_txn(0, 13'h0a0, 1'b0, 13'h05a5, 0, 0);
    push_txn(1, 13'h0b1, 1'b0, 13'h05a5, 0, 0);
    push_txn(2, 13'h0c2, 1'b0, 13'h05a5, 0, 0);
    push_txn(0, 13'h0a0, 1'b0, 13'h05a5, 0, 0);
    req = 3'b111;
    wait_start("rr_start");
    req = '0;
    wait_ack("rr_ack");

    // Watchdog: requester 1 never completes; requester 0 is served next.
    req_dat    = {13'h000, 13'h0d1, 13'h0d0};
    resp_delay = -1;
    resp_rx    = 13'h0777;
    push_txn(1, 13'h0d1, 1'b1, last_rsp, 0, TMO + 1);
    req = 3'b011;
    wait_ack("tmo_ack");
    resp_delay = 3;
    push_txn(0, 13'h0d0, 1'b0, 13'h0777, 0, 0);
    wait_start("tmo_next_start");
    req = '0;
    wait_ack("tmo_next_ack");

    // Committed grant: data and request change after the grant are ignored.
    req_dat    = {13'h000, 13'h0abc, 13'h000};
    resp_delay = 5;
    resp_rx    = 13'h1357;
    push_txn(1, 13'h0abc, 1'b0, 13'h1357, 0, 0);
    req = 3'b010;
    wait_start("commit_start");
    req_dat[2*WIDTH-1:WIDTH] = 13'h1fff;
    @(posedge clk);
    #1;
    req = '0;
    wait_ack("commit_ack");

    // Reset in the middle of WAIT, then pointer must be back at 0.
    req_dat    = {13'h0bad, 13'h000, 13'h000};
    resp_delay = -1;
    start_q.push_back('{idx: 2, tx: 13'h0bad, lat: 0});
    tgt_start++;
    req = 3'b100;
    wait_start("rst_start");
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    last_rsp = '0;
    have_ack = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_dat    = {13'h0222, 13'h0111, 13'h000};
    resp_rx    = 13'h0321;
    resp_delay = 2;
    push_txn(1, 13'h0111, 1'b0, 13'h0321, 0, 0);
    push_txn(2, 13'h0222, 1'b0, 13'h0321, 0, 0);
    req = 3'b110;
    wait_start("postrst_start");
    req = '0;
    wait_ack("postrst_ack");

    // Spurious m_done in IDLE and in GAP must leave everything untouched.
    spur_dat = 13'h1111;
    spur_go  = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("spur_idle_rsp", 64'(rsp_dat), 64'(last_rsp));
    req_dat    = {13'h000, 13'h000, 13'h0042};
    resp_rx    = 13'h0099;
    resp_delay = 1;
    push_txn(0, 13'h0042, 1'b0, 13'h0099, 0, 0);
    req = 3'b001;
    wait_start("spur_start");
    req = '0;
    wait_ack("spur_ack");
    spur_dat = 13'h0eee;
    spur_go  = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("spur_gap_rsp", 64'(rsp_dat), 64'(last_rsp));
    resp_rx    = 13'h0100;
    resp_delay = 2;
    push_txn(0, 13'h0042, 1'b0, 13'h0100, 0, 0);
    req = 3'b001;
    wait_start("spur_next_start");
    req = '0;
    wait_ack("spur_next_ack");

    repeat (10) @(posedge clk);
    #1;
    chk("start_q_drained", 64'(start_q.size()), 64'(0));
    chk("ack_q_drained", 64'(ack_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
